// File: rtl/seg7_capture_pkg.sv
// Shared 7-segment constants and decode result type for the display path.
package seg7_capture_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;

  // Active-low segment patterns, bit0 = a ... bit6 = g.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;
  localparam logic [CODE_W-1:0] CODE_ERR   = 4'hE;

  // Decoded digit: BCD code plus invalid-pattern flag.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              err;
  } dec_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Multiplexed segment bus plus the captured-frame outputs of the receiver.
interface seg7_capture_if
  import seg7_capture_pkg::*;
#(
  parameter int unsigned NDIG = 4
);

  logic [SEG_W-1:0]       seg;
  logic [NDIG-1:0]        dig_en;
  logic [CODE_W*NDIG-1:0] digits;
  logic [NDIG-1:0]        digit_err;
  logic                   frame_valid;
  logic                   sample_stb;
  logic [2:0]             sample_idx;

  // Display driver / stimulus side.
  modport master (
    output seg, dig_en,
    input  digits, digit_err, frame_valid, sample_stb, sample_idx
  );

  // Capture side.
  modport slave (
    input  seg, dig_en,
    output digits, digit_err, frame_valid, sample_stb, sample_idx
  );

endinterface

// File: rtl/seg7_capture_decode.sv
// Combinational inverse of the active-low segment table.
module seg7_capture_decode
  import seg7_capture_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output dec_t             dec_o
);

  // Map a lit pattern to BCD; blank is legal, anything unknown is flagged.
  always_comb begin
    dec_o = '{code: CODE_ERR, err: 1'b1};
    case (seg_i)
      SEG_0:     dec_o = '{code: 4'h0, err: 1'b0};
      SEG_1:     dec_o = '{code: 4'h1, err: 1'b0};
      SEG_2:     dec_o = '{code: 4'h2, err: 1'b0};
      SEG_3:     dec_o = '{code: 4'h3, err: 1'b0};
      SEG_4:     dec_o = '{code: 4'h4, err: 1'b0};
      SEG_5:     dec_o = '{code: 4'h5, err: 1'b0};
      SEG_6:     dec_o = '{code: 4'h6, err: 1'b0};
      SEG_7:     dec_o = '{code: 4'h7, err: 1'b0};
      SEG_8:     dec_o = '{code: 4'h8, err: 1'b0};
      SEG_9:     dec_o = '{code: 4'h9, err: 1'b0};
      SEG_BLANK: dec_o = '{code: CODE_BLANK, err: 1'b0};
      default:   dec_o = '{code: CODE_ERR, err: 1'b1};
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Receiver for a multiplexed 7-segment bus: debounces each digit dwell,
// decodes it, and publishes complete frames with a one-cycle valid pulse.
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 4
)(
  input  logic          clk,
  input  logic          rst,
  seg7_capture_if.slave bus
);

  localparam int unsigned IN_W  = NDIG + SEG_W;
  localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
  localparam int unsigned IDX_W = 3;
  localparam int unsigned LOW_W = 4;
  localparam int unsigned FRM_W = CODE_W * NDIG;

  logic [IN_W-1:0]   r_in_q, r_in_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NDIG-1:0]   r_dig_en;
  logic [SEG_W-1:0]  r_seg;
  logic [LOW_W-1:0]  n_low;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_ok;
  logic              fire_c;
  dec_t              dec;

  logic              sample_stb_q;
  logic [IDX_W-1:0]  sample_idx_q;
  dec_t              pend_q;

  logic [FRM_W-1:0]  stage_q, stage_d;
  logic [NDIG-1:0]   stage_err_q, stage_err_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic              publish_c;

  logic [FRM_W-1:0]  digits_q;
  logic [NDIG-1:0]   digit_err_q;
  logic              frame_valid_q;

  assign r_in_d   = {bus.dig_en, bus.seg};
  assign r_dig_en = r_in_q[IN_W-1:SEG_W];
  assign r_seg    = r_in_q[SEG_W-1:0];

  seg7_capture_decode u_decode (
    .seg_i (r_seg),
    .dec_o (dec)
  );

  // Count low enables and remember which one; exactly one low qualifies.
  always_comb begin
    n_low   = '0;
    sel_idx = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (!r_dig_en[i]) begin
        n_low   = n_low + LOW_W'(1);
        sel_idx = IDX_W'(i);
      end
    end
    sel_ok = (n_low == LOW_W'(1));
  end

  // Stability counter restarts on any bus change and saturates, so a
  // held dwell crosses STABLE_CYC-1 exactly once.
  always_comb begin
    if (r_in_d != r_in_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STABLE_CYC)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    fire_c = sel_ok && (cnt_d == CNT_W'(STABLE_CYC - 1));
  end

  // Input register and stability counter; idle bus after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q <= '1;
      cnt_q  <= '0;
    end else begin
      r_in_q <= r_in_d;
      cnt_q  <= cnt_d;
    end
  end

  // Latch the decoded dwell; the pending copy is immune to later bus changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_stb_q <= 1'b0;
      sample_idx_q <= '0;
      pend_q       <= '{code: CODE_BLANK, err: 1'b0};
    end else begin
      sample_stb_q <= fire_c;
      if (fire_c) begin
        sample_idx_q <= sel_idx;
        pend_q       <= dec;
      end
    end
  end

  // Merge the pending sample into staging and detect a full frame.
  always_comb begin
    stage_d     = stage_q;
    stage_err_d = stage_err_q;
    seen_d      = seen_q;
    publish_c   = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (sample_stb_q && (sample_idx_q == IDX_W'(i))) begin
        stage_d[CODE_W*i +: CODE_W] = pend_q.code;
        stage_err_d[i]              = pend_q.err;
        seen_d[i]                   = 1'b1;
      end
    end
    if (&seen_d) begin
      publish_c = 1'b1;
      seen_d    = '0;
    end
  end

  // Staging slots and the seen mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= {NDIG{CODE_BLANK}};
      stage_err_q <= '0;
      seen_q      <= '0;
    end else begin
      stage_q     <= stage_d;
      stage_err_q <= stage_err_d;
      seen_q      <= seen_d;
    end
  end

  // Published frame changes only when a frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q      <= {NDIG{CODE_BLANK}};
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= publish_c;
      if (publish_c) begin
        digits_q    <= stage_d;
        digit_err_q <= stage_err_d;
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_err   = digit_err_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sample_stb  = sample_stb_q;
  assign bus.sample_idx  = sample_idx_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (NDIG=4, STABLE_CYC=4).
module tb_seg7_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  int   stb_cnt = 0;
  int   fv_cnt  = 0;
  int   stb0, fv0;

  seg7_capture_if #(.NDIG(4)) bus_if ();

  seg7_capture #(.NDIG(4), .STABLE_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus_if.sample_stb === 1'b1)  stb_cnt = stb_cnt + 1;
    if (bus_if.frame_valid === 1'b1) fv_cnt  = fv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pins(input logic [3:0] en, input logic [6:0] sg);
    bus_if.dig_en = en;
    bus_if.seg    = sg;
  endtask

  // Hold a bus value for n edges; called and returns just after a rising edge.
  task automatic dwell(input logic [3:0] en, input logic [6:0] sg, input int n);
    set_pins(en, sg);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    set_pins(4'b1111, 7'h7F);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_digits", 32'(bus_if.digits), 32'hFFFF);
    chk("rst_err", 32'(bus_if.digit_err), 32'h0);
    chk("rst_fv", 32'(bus_if.frame_valid), 32'h0);
    chk("rst_stb", 32'(bus_if.sample_stb), 32'h0);
    chk("rst_idx", 32'(bus_if.sample_idx), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle bus produces nothing
    repeat (10) @(posedge clk); #1;
    chk("idle_stb", 32'(stb_cnt), 32'd0);
    chk("idle_fv", 32'(fv_cnt), 32'd0);
    chk("idle_digits", 32'(bus_if.digits), 32'hFFFF);

    // Frame 1,2,3,4 with exact latency checks on first and last dwell
    stb0 = stb_cnt; fv0 = fv_cnt;
    set_pins(4'b1110, 7'b1111001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lat_stb_early", 32'(bus_if.sample_stb), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("lat_stb_on", 32'(bus_if.sample_stb), 32'h1);
    chk("lat_idx0", 32'(bus_if.sample_idx), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("stb_one_cycle", 32'(bus_if.sample_stb), 32'h0);
    @(posedge clk); #1;
    dwell(4'b1101, 7'b0100100, 6);
    dwell(4'b1011, 7'b0110000, 6);
    set_pins(4'b0111, 7'b0011001);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("f1_stb_idx3", 32'({bus_if.sample_stb, bus_if.sample_idx}), 32'hB);
    chk("f1_fv_early", 32'(bus_if.frame_valid), 32'h0);
    chk("f1_no_partial", 32'(bus_if.digits), 32'hFFFF);
    @(posedge clk); @(negedge clk);
    chk("f1_fv_on", 32'(bus_if.frame_valid), 32'h1);
    chk("f1_digits", 32'(bus_if.digits), 32'h4321);
    chk("f1_err", 32'(bus_if.digit_err), 32'h0);
    @(posedge clk); #1;
    dwell(4'b1111, 7'h7F, 4);
    chk("f1_stb_cnt", 32'(stb_cnt - stb0), 32'd4);
    chk("f1_fv_cnt", 32'(fv_cnt - fv0), 32'd1);
    chk("idx_held", 32'(bus_if.sample_idx), 32'h3);

    // Invalid pattern on digit 2, blank on digit 3
    stb0 = stb_cnt; fv0 = fv_cnt;
    dwell(4'b1110, 7'b1111001, 6);
    dwell(4'b1101, 7'b0100100, 6);
    dwell(4'b1011, 7'b1010101, 6);
    dwell(4'b0111, 7'b1111111, 6);
    dwell(4'b1111, 7'h7F, 4);
    chk("f2_digits", 32'(bus_if.digits), 32'hFE21);
    chk("f2_err", 32'(bus_if.digit_err), 32'h4);
    chk("f2_fv_cnt", 32'(fv_cnt - fv0), 32'd1);

    // Short glitch and a two-hot select produce no sample
    stb0 = stb_cnt; fv0 = fv_cnt;
    dwell(4'b1110, 7'b1000000, 2);
    dwell(4'b1111, 7'h7F, 6);
    dwell(4'b1100, 7'b0110000, 6);
    dwell(4'b1111, 7'h7F, 2);
    chk("glitch_stb", 32'(stb_cnt - stb0), 32'd0);
    chk("glitch_fv", 32'(fv_cnt - fv0), 32'd0);
    chk("glitch_digits", 32'(bus_if.digits), 32'hFE21);
    // Valid frame with a seg glitch splitting digit 1's dwell
    dwell(4'b1110, 7'b1000000, 6);
    dwell(4'b1101, 7'b0010000, 3);
    dwell(4'b1101, 7'b0110110, 2);
    dwell(4'b1101, 7'b0010000, 6);
    dwell(4'b1011, 7'b0000000, 6);
    dwell(4'b0111, 7'b1111000, 6);
    dwell(4'b1111, 7'h7F, 3);
    chk("f3_stb_cnt", 32'(stb_cnt - stb0), 32'd4);
    chk("f3_fv_cnt", 32'(fv_cnt - fv0), 32'd1);
    chk("f3_digits", 32'(bus_if.digits), 32'h7890);

    // Reset mid-frame discards the partial frame
    dwell(4'b1110, 7'b1111001, 6);
    dwell(4'b1101, 7'b0100100, 6);
    set_pins(4'b1111, 7'h7F);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_digits", 32'(bus_if.digits), 32'hFFFF);
    chk("mid_rst_stb", 32'(bus_if.sample_stb), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    stb0 = stb_cnt; fv0 = fv_cnt;
    dwell(4'b1011, 7'b1111000, 6);
    dwell(4'b0111, 7'b0000000, 6);
    dwell(4'b1111, 7'h7F, 2);
    chk("post_rst_no_frame", 32'(fv_cnt - fv0), 32'd0);
    dwell(4'b1110, 7'b0010010, 6);
    dwell(4'b1101, 7'b0000010, 6);
    dwell(4'b1111, 7'h7F, 2);
    chk("f4_fv_cnt", 32'(fv_cnt - fv0), 32'd1);
    chk("f4_digits", 32'(bus_if.digits), 32'h8765);
    chk("f4_err", 32'(bus_if.digit_err), 32'h0);

    // Repeat sample overwrites; long hold samples once
    stb0 = stb_cnt; fv0 = fv_cnt;
    dwell(4'b1110, 7'b0110000, 6);
    dwell(4'b1101, 7'b1111001, 6);
    dwell(4'b1110, 7'b0010000, 6);
    dwell(4'b1011, 7'b0100100, 6);
    dwell(4'b0111, 7'b0011001, 20);
    chk("f5_stb_cnt", 32'(stb_cnt - stb0), 32'd5);
    chk("f5_fv_cnt", 32'(fv_cnt - fv0), 32'd1);
    chk("f5_digits", 32'(bus_if.digits), 32'h4219);
    chk("f5_idx", 32'(bus_if.sample_idx), 32'h3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receiving end of the multiplexed 7-segment display interface. The block watches an active-low, time-multiplexed segment bus (segments a–g plus one-hot active-low digit enables), waits for each digit dwell to settle, and decodes the lit pattern back to a 4-bit BCD code. It assembles a full frame of NDIG digits and presents it with a one-cycle valid pulse. It serves as the loopback checker and scoreboard source for any display driver in the design.

## Interface
- NDIG, 4: number of multiplexed digits (2..8).
- STABLE_CYC, 4: registered bus must hold this many consecutive cycles before a dwell is sampled (>=2).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- seg  in  7  segment lines, active-low; bit0=a … bit6=g.
- dig_en  in  NDIG  digit enables, active-low, expected one-hot-low.
- digits  out  4*NDIG  published frame; digit i at [4i+3:4i]; 4'hF = blank, 4'hE = invalid pattern.
- digit_err  out  NDIG  per-digit invalid-pattern flag for the published frame.
- frame_valid  out  1  one-cycle pulse; a new frame was published this cycle.
- sample_stb  out  1  one-cycle pulse; a dwell was sampled this cycle.
- sample_idx  out  3  digit index of the current sample_stb; held otherwise.

## Operation
- Input stage: {dig_en, seg} is registered once into r_in. All logic below acts on r_in.
- Stability counter cnt:
  - Cleared to 0 whenever r_in differs from its previous value.
  - Otherwise increments, saturating at STABLE_CYC.
  - One sample per dwell: the sample fires only when cnt equals STABLE_CYC-1.
- Sample qualification: r_dig_en must have exactly one bit low. Zero or multiple low bits give no sample_stb, and the dwell is ignored.
- Decode (inverse of the team's active-low table):
  - 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
  - 7'b1111111 gives 4'hF (blank, not an error).
  - Any other pattern gives 4'hE with err=1.
- On a sample: the decoded code and err are written into staging slot idx, and seen_mask[idx] is set. A repeat sample of an already-seen digit overwrites its slot.
- Frame completion: when a sample makes seen_mask all-ones:
  - On the next edge, staging is copied to digits/digit_err.
  - frame_valid pulses for that cycle.
  - seen_mask clears in the same edge.
- Published outputs change only on frame completion. Partial frames are never visible.

## Timing
- Reset values:
  - digits = all 4'hF; digit_err = 0; frame_valid = 0; sample_stb = 0; sample_idx = 0.
  - r_in = all-ones, so the bus is idle/blank.
  - cnt, staging (4'hF), and seen_mask are cleared.
- Latency: pins stable from edge k are captured in r_in at edge k+1 with cnt=0.
  - sample_stb is high in the cycle after edge k+STABLE_CYC.
  - The staging write happens at edge k+STABLE_CYC+1.
  - If that sample completes the frame, frame_valid is high in the cycle after edge k+STABLE_CYC+1.
- Glitches shorter than STABLE_CYC registered cycles never produce a sample.
- A bus change in the exact cycle sample_stb is high does not cancel that sample; the new value starts a fresh dwell.
- rst asserted mid-frame: the partial frame is discarded, and all outputs take reset values at the next edge.
- An unchanged bus held indefinitely yields exactly one sample.

## Structure
- Shared package/include seg7_defs: the ten segment pattern constants, SEG_BLANK=7'h7F, CODE_BLANK=4'hF, CODE_ERR=4'hE. The display driver uses the same constants.
- Sub-module seg7_decode (combinational): 7-bit pattern in; 4-bit code and err out.
- Top module seg7_capture holds the input register, stability counter, qualification, staging, and publish logic.
- Estimated size: roughly 150–200 lines.

## Test plan
- Reset, then idle bus (all 1s) -> no sample_stb and no frame_valid; digits=16'hFFFF.
- NDIG=4, STABLE_CYC=4; each dwell held 6 cycles in order, with dig_en 1110 plus 1.pattern (7'b1111001), 1101 plus 2, 1011 plus 3, 0111 plus 4 -> four sample_stb pulses (idx 0..3), one frame_valid, digits=16'h4321, digit_err=0.
- Digit 2 carries 7'b1010101 and digit 3 is blank -> digits=16'hFE21, digit_err=4'b0100.
- 2-cycle glitch on seg within a dwell, and a dwell with dig_en=1100 -> no sample for the glitch or the invalid select; the frame completes only after valid dwells.
- rst pulsed after 2 of 4 digits are sampled, then a full frame 5,6,7,8 -> single frame_valid with digits=16'h8765; earlier digits are never published.
- Digit 0 sampled twice (value 3, then 9) before the frame completes -> published digit 0 = 4'h9.
